// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the round-robin SRAM controller.
// Holds the FSM state encoding used by the controller.
package sram_ctrl_pkg;

    localparam int unsigned STATE_W = 2;

    typedef logic [STATE_W-1:0] state_t;

    localparam state_t ARB = 2'd0;
    localparam state_t WR  = 2'd1;
    localparam state_t RD1 = 2'd2;
    localparam state_t RD2 = 2'd3;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester after last_grant.
// The search wraps modulo N; grant is one-hot or zero.
module rr_arbiter #(
    parameter int unsigned N  = 2,
    parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_grant,
    input  logic          enable,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);

    logic          found;
    int unsigned   cand;
    logic [IW-1:0] cand_idx;

    always_comb begin
        grant    = '0;
        idx      = '0;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned off = 1; off <= N; off++) begin
            cand     = (32'(last_grant) + off) % N;
            cand_idx = IW'(cand);
            if (enable && !found && req[cand_idx]) begin
                grant[cand_idx] = 1'b1;
                idx             = cand_idx;
                found           = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sram_rr_controller.sv
// Shares one single-port synchronous RAM between NUM_REQ valid/ready requesters.
// One access in flight: 1-cycle writes, 2-cycle reads (issue, then output-enable/capture).
module sram_rr_controller
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ-1:0]               req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
    output logic [NUM_REQ-1:0]               rsp_valid,
    output logic [DATA_WIDTH-1:0]            rsp_rdata,
    output logic                             mem_cs,
    output logic                             mem_we,
    output logic                             mem_oe,
    output logic [ADDR_WIDTH-1:0]            mem_addr,
    output logic [DATA_WIDTH-1:0]            mem_wdata,
    output logic                             mem_wdata_oe,
    input  logic [DATA_WIDTH-1:0]            mem_rdata
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       last_q;
    logic [IDX_W-1:0]       id_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [DATA_WIDTH-1:0]  wdata_q;
    logic [NUM_REQ-1:0]     rsp_valid_q;
    logic [DATA_WIDTH-1:0]  rsp_rdata_q;

    logic                   arb_en;
    logic [NUM_REQ-1:0]     gnt;
    logic [IDX_W-1:0]       gnt_idx;
    logic                   accept;

    // Reset also masks the grant so req_ready reads 0 while rst is held.
    assign arb_en = (state_q == ARB) && !rst;
    assign accept = |gnt;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IDX_W)
    ) u_arb (
        .req        (req_valid),
        .last_grant (last_q),
        .enable     (arb_en),
        .grant      (gnt),
        .idx        (gnt_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ARB: begin
                if (accept) begin
                    state_d = req_we[gnt_idx] ? WR : RD1;
                end
            end
            WR:      state_d = ARB;
            RD1:     state_d = RD2;
            RD2:     state_d = ARB;
            default: state_d = ARB;
        endcase
    end

    // Request capture and read-response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q      <= IDX_W'(NUM_REQ - 1);
            id_q        <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
        end else begin
            if (accept) begin
                last_q  <= gnt_idx;
                id_q    <= gnt_idx;
                addr_q  <= req_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
                wdata_q <= req_wdata[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
            end
            rsp_valid_q <= (state_q == RD2) ? (NUM_REQ'(1) << id_q) : '0;
            if (state_q == RD2) begin
                rsp_rdata_q <= mem_rdata;
            end
        end
    end

    // RAM pins decode only registered state, never req_*.
    always_comb begin
        mem_cs       = 1'b0;
        mem_we       = 1'b0;
        mem_oe       = 1'b0;
        mem_wdata_oe = 1'b0;
        unique case (state_q)
            WR: begin
                mem_cs       = 1'b1;
                mem_we       = 1'b1;
                mem_wdata_oe = 1'b1;
            end
            RD1: begin
                mem_cs = 1'b1;
            end
            RD2: begin
                mem_cs = 1'b1;
                mem_oe = 1'b1;
            end
            default: begin
                mem_cs = 1'b0;
            end
        endcase
    end

    assign req_ready = gnt;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

endmodule

// File: doc/sram_rr_controller.md
Name: sram_rr_controller

Overview:
- Round-robin controller that shares one single-port synchronous RAM (cs/we/oe, registered read, shared tri-state data bus) between NUM_REQ requesters.
- Each requester uses a valid/ready request channel and a one-cycle read-response pulse.
- The controller sequences the RAM pins: 1-cycle writes and 2-cycle reads (issue, then output-enable/capture).
- It sits between client blocks and the RAM instance. Integration ties the bus as: data = mem_wdata_oe ? mem_wdata : 'z; mem_rdata = data.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
ADDR_WIDTH, 4, RAM address width
DATA_WIDTH, 32, RAM data width

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  synchronous reset, active-high
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester accept, one-hot or zero
req_we  in  NUM_REQ  1=write, 0=read
req_addr  in  NUM_REQ*ADDR_WIDTH  flattened addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
req_wdata  in  NUM_REQ*DATA_WIDTH  flattened write data, same packing
rsp_valid  out  NUM_REQ  one-cycle read-data pulse to the owning requester
rsp_rdata  out  DATA_WIDTH  shared read data, valid only with rsp_valid
mem_cs, mem_we, mem_oe  out  1 each  RAM controls
mem_addr  out  ADDR_WIDTH  RAM address
mem_wdata  out  DATA_WIDTH  data for the bus
mem_wdata_oe  out  1  controller drives the bus
mem_rdata  in  DATA_WIDTH  bus sampled value

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst).
- Reset values: state=ARB, last_grant=NUM_REQ-1, req_ready=0, rsp_valid=0, rsp_rdata=0, and mem_cs/we/oe/wdata_oe=0. mem_addr and mem_wdata are 0.
- States: ARB, WR, RD1, RD2.
  - ARB: mem_cs=0. If any req_valid, the winner is the first set bit searching from last_grant+1 with wrap mod NUM_REQ.
    - req_ready[winner]=1 combinationally in this cycle only.
    - On that posedge, latch addr, we, wdata and id, and set last_grant=winner.
    - Next state is WR if we=1, else RD1.
    - No valid: stay in ARB, req_ready=0.
  - WR: mem_cs=1, mem_we=1, mem_oe=0, mem_wdata_oe=1. The RAM writes at the end of this cycle. Next state is ARB.
  - RD1: mem_cs=1, mem_we=0, mem_oe=0, mem_wdata_oe=0. The RAM registers the read. Next state is RD2.
  - RD2: mem_cs=1, mem_we=0, mem_oe=1, mem_wdata_oe=0, same address. On the posedge, capture mem_rdata into rsp_rdata and set rsp_valid[id]=1 for the next cycle. Next state is ARB.
- req_ready is 0 in WR, RD1 and RD2; at most one request is in flight.
- Memory pins are pure decodes of the registered state and latched fields. No combinational path from req_* to mem_*.
- Latency, with acceptance in cycle A:
  - Write is committed at the end of A+1; the next acceptance is possible in A+2.
  - Read has rsp_valid in A+3, concurrent with a possible new acceptance.
- Throughput: 1 write per 2 cycles; 1 read per 3 cycles.
- Bus ownership: the controller drives only in WR; the RAM drives only in RD2. The controller never sets mem_wdata_oe and mem_oe together.
- Requester rules:
  - Fields stay stable while valid && !ready.
  - Valid is not withdrawn before ready.
  - A requester may assert valid again in the cycle after its ready.
  - Responses are not back-pressured.
- Fairness: a continuously-valid requester waits at most NUM_REQ-1 grants.
- Simultaneous events: rsp_valid for one request and req_ready for another may occur in the same cycle.
- rsp_rdata holds its last value after rsp_valid drops.
- Reset mid-operation: the in-flight access is abandoned, no rsp_valid is produced, and a write in WR at reset is not guaranteed. All outputs take reset values on the next cycle.

Decomposition:
- Shared package `sram_ctrl_pkg`: state encoding localparams (ARB=2'd0, WR=2'd1, RD1=2'd2, RD2=2'd3).
- Sub-module `rr_arbiter #(N)`: inputs req, last_grant, enable; outputs one-hot grant and index. Purely combinational, reused by other shared-resource blocks.
- FSM, capture registers and pin decode stay in `sram_rr_controller`.

Test Plan:
- Reset then idle (no valid for 5 cycles) -> req_ready=0, mem_cs=0, rsp_valid=0 throughout.
- Req0 writes addr 3 = 0xDEADBEEF, then req0 reads addr 3 -> ready in A, mem_cs&mem_we in A+1, read rsp_valid[0]=1 with rsp_rdata=0xDEADBEEF exactly 3 cycles after its acceptance.
- Req0 and req1 both continuously valid with reads from addr 1 and 2 (preloaded 0x11, 0x22) -> grants alternate 0,1,0,1; each rsp_valid goes to the correct requester with the correct data.
- Only req1 valid after reset -> granted immediately. Then both valid -> req0 wins (pointer wrap), then req1.
- Write in WR and a new read accepted right after -> no cycle with mem_wdata_oe&mem_oe; the read returns the newly written value.
- rst asserted in RD2 -> no rsp_valid, state ARB, req_ready re-arbitrates on the first cycle after reset deassertion.
